// File: rtl/shift_operand_sequencer.sv
// Operand-2 front end for the barrel shifter: decodes one data-processing instruction,
// fetches Rm (and Rs for register shifts) and presents a resolved shift request.
// Latency accept->op_valid: 1 (imm operand), 2 (reg, imm shift), 3 (reg, reg shift); the
// request is held stable until op_ready, and no instruction is accepted outside IDLE.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   instr_valid/instr_ready instruction handshake; instr[25] and instr[11:0] are decoded
//   rf_rd_en/rf_addr        combinational register-file read request
//   rf_rdata                register-file data, valid the cycle after the request
//   op_valid/op_ready       shift request handshake
//   b_bus, shift_type, shift_amount_imm, shift_amount_reg, reg_shift, rrx  request fields
module shift_operand_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        rf_rd_en,
  output logic [3:0]  rf_addr,
  input  logic [31:0] rf_rdata,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] b_bus,
  output logic [1:0]  shift_type,
  output logic [4:0]  shift_amount_imm,
  output logic [7:0]  shift_amount_reg,
  output logic        reg_shift,
  output logic        rrx
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ_RM = 2'd1,
    READ_RS = 2'd2,
    ISSUE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] instr_q, instr_d;
  logic        op_valid_q, op_valid_d;
  logic [31:0] b_bus_q, b_bus_d;
  logic [1:0]  shift_type_q, shift_type_d;
  logic [4:0]  shift_amount_imm_q, shift_amount_imm_d;
  logic [7:0]  shift_amount_reg_q, shift_amount_reg_d;
  logic        reg_shift_q, reg_shift_d;
  logic        rrx_q, rrx_d;

  logic        accept;
  logic [4:0]  imm_amt;

  // Only bit 25 and the operand-2 field carry meaning here.
  logic        unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:26], instr[24:12]};

  // Gated by reset_n so the port reads 0 while reset is held, even though state is IDLE.
  assign instr_ready = (state_q == IDLE) && reset_n;
  assign accept      = instr_valid && instr_ready;
  assign imm_amt     = instr_q[11:7];

  // Register-file read port: Rm straight from the offered word in the accept cycle,
  // Rs from the latched word in READ_RM so data lands as READ_RS is entered.
  always_comb begin
    rf_rd_en = 1'b0;
    rf_addr  = 4'd0;
    if (accept && !instr[25]) begin
      rf_rd_en = 1'b1;
      rf_addr  = instr[3:0];
    end else if (state_q == READ_RM && instr_q[4]) begin
      rf_rd_en = 1'b1;
      rf_addr  = instr_q[11:8];
    end
  end

  always_comb begin
    state_d            = state_q;
    instr_d            = instr_q;
    b_bus_d            = b_bus_q;
    shift_type_d       = shift_type_q;
    shift_amount_imm_d = shift_amount_imm_q;
    shift_amount_reg_d = shift_amount_reg_q;
    reg_shift_d        = reg_shift_q;
    rrx_d              = rrx_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          instr_d = instr[11:0];
          if (instr[25]) begin
            // Rotated 8-bit immediate: ROR by twice the 4-bit rotate field.
            b_bus_d            = {24'b0, instr[7:0]};
            shift_type_d       = 2'b11;
            shift_amount_imm_d = {instr[11:8], 1'b0};
            shift_amount_reg_d = 8'd0;
            reg_shift_d        = 1'b0;
            rrx_d              = 1'b0;
            state_d            = ISSUE;
          end else begin
            state_d = READ_RM;
          end
        end
      end

      READ_RM: begin
        b_bus_d            = rf_rdata;
        shift_type_d       = instr_q[6:5];
        shift_amount_imm_d = 5'd0;
        shift_amount_reg_d = 8'd0;
        reg_shift_d        = 1'b0;
        rrx_d              = 1'b0;
        if (instr_q[4]) begin
          state_d = READ_RS;
        end else begin
          state_d = ISSUE;
          if (imm_amt != 5'd0) begin
            shift_amount_imm_d = imm_amt;
          end else begin
            // A zero amount re-encodes: LSR/ASR #0 mean #32 (beyond the 5-bit
            // immediate path, so route via the register path), ROR #0 means RRX.
            case (instr_q[6:5])
              2'b01, 2'b10: begin
                reg_shift_d        = 1'b1;
                shift_amount_reg_d = 8'd32;
              end
              2'b11: begin
                rrx_d              = 1'b1;
                shift_amount_imm_d = 5'd1;
              end
              default: ;
            endcase
          end
        end
      end

      READ_RS: begin
        shift_amount_reg_d = rf_rdata[7:0];
        shift_amount_imm_d = 5'd0;
        reg_shift_d        = 1'b1;
        rrx_d              = 1'b0;
        state_d            = ISSUE;
      end

      ISSUE: begin
        if (op_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign op_valid_d = (state_d == ISSUE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= IDLE;
      instr_q            <= 12'd0;
      op_valid_q         <= 1'b0;
      b_bus_q            <= 32'd0;
      shift_type_q       <= 2'd0;
      shift_amount_imm_q <= 5'd0;
      shift_amount_reg_q <= 8'd0;
      reg_shift_q        <= 1'b0;
      rrx_q              <= 1'b0;
    end else begin
      state_q            <= state_d;
      instr_q            <= instr_d;
      op_valid_q         <= op_valid_d;
      b_bus_q            <= b_bus_d;
      shift_type_q       <= shift_type_d;
      shift_amount_imm_q <= shift_amount_imm_d;
      shift_amount_reg_q <= shift_amount_reg_d;
      reg_shift_q        <= reg_shift_d;
      rrx_q              <= rrx_d;
    end
  end

  assign op_valid         = op_valid_q;
  assign b_bus            = b_bus_q;
  assign shift_type       = shift_type_q;
  assign shift_amount_imm = shift_amount_imm_q;
  assign shift_amount_reg = shift_amount_reg_q;
  assign reg_shift        = reg_shift_q;
  assign rrx              = rrx_q;

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Directed bench for shift_operand_sequencer with a small synchronous-read register file.
module tb_shift_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        rf_rd_en;
  logic [3:0]  rf_addr;
  logic [31:0] rf_rdata = 32'd0;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] b_bus;
  logic [1:0]  shift_type;
  logic [4:0]  shift_amount_imm;
  logic [7:0]  shift_amount_reg;
  logic        reg_shift;
  logic        rrx;

  int total = 0;
  int bad   = 0;

  logic [31:0] regs [16];
  logic [3:0]  addr_log [$];
  int          n0;

  shift_operand_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_ready      (instr_ready),
    .rf_rd_en         (rf_rd_en),
    .rf_addr          (rf_addr),
    .rf_rdata         (rf_rdata),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .b_bus            (b_bus),
    .shift_type       (shift_type),
    .shift_amount_imm (shift_amount_imm),
    .shift_amount_reg (shift_amount_reg),
    .reg_shift        (reg_shift),
    .rrx              (rrx)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file; also logs every read address issued.
  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rdata <= regs[rf_addr];
      addr_log.push_back(rf_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer a register-operand / immediate-shift instruction and advance to ISSUE.
  task automatic run_regimm(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    regs[1] = 32'h1234_5678;
    regs[2] = 32'h8000_0001;
    regs[3] = 32'h0000_0108;
    regs[4] = 32'hF000_0000;

    // Reset state, with an instruction offered that must be ignored.
    reset_n     = 1'b0;
    instr_valid = 1'b1;
    instr       = 32'h0000_0005;
    op_ready    = 1'b0;
    #2;
    chk("rst_instr_ready", instr_ready, 0);
    chk("rst_rf_rd_en", rf_rd_en, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_b_bus", b_bus, 0);
    instr_valid = 1'b0;
    #6;
    reset_n = 1'b1;
    #1;
    chk("post_rst_instr_ready", instr_ready, 1);

    // Immediate operand: 0xFF ROR 6.
    op_ready    = 1'b1;
    instr       = 32'h02A0_03FF;
    instr_valid = 1'b1;
    #1;
    chk("imm_no_rf_read", rf_rd_en, 0);
    tick();
    instr_valid = 1'b0;
    chk("imm_op_valid", op_valid, 1);
    chk("imm_b_bus", b_bus, 32'h0000_00FF);
    chk("imm_type", shift_type, 2'b11);
    chk("imm_amt", shift_amount_imm, 5'd6);
    chk("imm_reg_shift", reg_shift, 0);
    chk("imm_instr_ready_busy", instr_ready, 0);
    tick();
    chk("imm_op_valid_drop", op_valid, 0);
    chk("imm_instr_ready_back", instr_ready, 1);

    // Register operand, LSL #4 of r2.
    instr       = 32'hE080_0202;
    instr_valid = 1'b1;
    #1;
    chk("lsl_rm_rd_en", rf_rd_en, 1);
    chk("lsl_rm_addr", rf_addr, 4'd2);
    tick();
    instr_valid = 1'b0;
    chk("lsl_t1_op_valid", op_valid, 0);
    chk("lsl_t1_no_rs_read", rf_rd_en, 0);
    tick();
    chk("lsl_op_valid", op_valid, 1);
    chk("lsl_b_bus", b_bus, 32'h8000_0001);
    chk("lsl_type", shift_type, 2'b00);
    chk("lsl_amt", shift_amount_imm, 5'd4);
    chk("lsl_reg_shift", reg_shift, 0);
    chk("lsl_amt_reg", shift_amount_reg, 0);
    tick();

    // LSR #0 of r4 -> shift by 32 via register path.
    run_regimm(32'hE1A0_0024);
    chk("lsr0_op_valid", op_valid, 1);
    chk("lsr0_b_bus", b_bus, 32'hF000_0000);
    chk("lsr0_type", shift_type, 2'b01);
    chk("lsr0_reg_shift", reg_shift, 1);
    chk("lsr0_amt_reg", shift_amount_reg, 8'd32);
    chk("lsr0_rrx", rrx, 0);
    tick();

    // ASR #0 of r4.
    run_regimm(32'hE1A0_0044);
    chk("asr0_type", shift_type, 2'b10);
    chk("asr0_reg_shift", reg_shift, 1);
    chk("asr0_amt_reg", shift_amount_reg, 8'd32);
    tick();

    // ROR #0 of r4 -> RRX.
    run_regimm(32'hE1A0_0064);
    chk("rrx_rrx", rrx, 1);
    chk("rrx_type", shift_type, 2'b11);
    chk("rrx_amt", shift_amount_imm, 5'd1);
    chk("rrx_reg_shift", reg_shift, 0);
    chk("rrx_amt_reg", shift_amount_reg, 0);
    tick();

    // LSR #31 of r4: largest nonzero immediate stays on the immediate path.
    run_regimm(32'hE1A0_0FA4);
    chk("lsr31_amt", shift_amount_imm, 5'd31);
    chk("lsr31_reg_shift", reg_shift, 0);
    chk("lsr31_rrx", rrx, 0);
    tick();

    // Register shift: r1 ROR r3.
    n0          = addr_log.size();
    instr       = 32'hE1A0_0371;
    instr_valid = 1'b1;
    #1;
    chk("rs_rm_addr", rf_addr, 4'd1);
    tick();
    instr_valid = 1'b0;
    chk("rs_rs_rd_en", rf_rd_en, 1);
    chk("rs_rs_addr", rf_addr, 4'd3);
    chk("rs_t1_op_valid", op_valid, 0);
    tick();
    chk("rs_t2_op_valid", op_valid, 0);
    tick();
    chk("rs_op_valid", op_valid, 1);
    chk("rs_b_bus", b_bus, 32'h1234_5678);
    chk("rs_amt_reg", shift_amount_reg, 8'h08);
    chk("rs_reg_shift", reg_shift, 1);
    chk("rs_type", shift_type, 2'b11);
    chk("rs_amt_imm", shift_amount_imm, 0);
    chk("rs_read_count", addr_log.size() - n0, 2);
    if (addr_log.size() >= n0 + 2) begin
      chk("rs_log_first", addr_log[n0], 4'd1);
      chk("rs_log_second", addr_log[n0+1], 4'd3);
    end
    tick();

    // Backpressure: LSL #4 of r2 held for 5 cycles while instr_valid pulses.
    op_ready = 1'b0;
    run_regimm(32'hE080_0202);
    chk("bp_op_valid_start", op_valid, 1);
    for (int i = 0; i < 5; i++) begin
      instr       = 32'h02A0_03FF;
      instr_valid = (i % 2 == 0);
      #1;
      chk("bp_instr_ready", instr_ready, 0);
      chk("bp_rf_rd_en", rf_rd_en, 0);
      tick();
      chk("bp_op_valid", op_valid, 1);
      chk("bp_b_bus", b_bus, 32'h8000_0001);
      chk("bp_amt", shift_amount_imm, 5'd4);
    end
    instr_valid = 1'b0;
    op_ready    = 1'b1;
    tick();
    chk("bp_release_op_valid", op_valid, 0);
    chk("bp_release_ready", instr_ready, 1);
    tick();
    chk("bp_nothing_queued", op_valid, 0);

    // Throughput: two immediate operands back to back, instr_valid held high.
    instr       = 32'h02A0_03FF;
    instr_valid = 1'b1;
    tick();
    instr = 32'h0200_0A12;
    chk("tp_first_valid", op_valid, 1);
    chk("tp_first_b_bus", b_bus, 32'h0000_00FF);
    tick();
    chk("tp_gap_op_valid", op_valid, 0);
    tick();
    instr_valid = 1'b0;
    chk("tp_second_valid", op_valid, 1);
    chk("tp_second_b_bus", b_bus, 32'h0000_0012);
    chk("tp_second_amt", shift_amount_imm, 5'd20);
    tick();

    // Reset while in READ_RS aborts the instruction.
    instr       = 32'hE1A0_0371;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_b_bus", b_bus, 0);
    chk("arst_type", shift_type, 0);
    chk("arst_op_valid", op_valid, 0);
    chk("arst_instr_ready", instr_ready, 0);
    chk("arst_rf_rd_en", rf_rd_en, 0);
    chk("arst_rf_addr", rf_addr, 0);
    chk("arst_reg_shift", reg_shift, 0);
    chk("arst_amt_reg", shift_amount_reg, 0);
    tick();
    #2;
    reset_n = 1'b1;
    #1;
    chk("arst_release_ready", instr_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_op_valid", op_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_operand_sequencer.md
# shift_operand_sequencer

Front-end driver for the barrel shifter. It accepts one ARM data-processing instruction per handshake and decodes the operand-2 field. It fetches Rm, and Rs when needed, from a synchronous-read register file. It then presents a stable, fully resolved shift request (value, type, amount, path select) to the shifter/ALU stage. It owns the extra cycle for register-specified shifts and the ARM encoding special cases that the shifter's 5-bit immediate amount cannot express.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- clk  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- instr_valid  in  1  an instruction is offered.
- instr  in  32  data-processing instruction word; only bits [25], [11:0] are used.
- instr_ready  out  1  sequencer can accept; high only in IDLE with reset_n high.
- rf_rd_en  out  1  register-file read strobe (combinational).
- rf_addr  out  4  register-file read address (combinational).
- rf_rdata  in  32  read data; valid the cycle after rf_rd_en/rf_addr are presented.
- op_valid  out  1  shift request valid.
- op_ready  in  1  shifter/ALU stage consumes the request.
- b_bus  out  32  value to shift.
- shift_type  out  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- shift_amount_imm  out  5  immediate shift amount.
- shift_amount_reg  out  8  register shift amount (Rs[7:0] or forced 32).
- reg_shift  out  1  1 selects shift_amount_reg path.
- rrx  out  1  rotate-right-extended request; downstream inserts carry.

## Operation
States: IDLE, READ_RM, READ_RS, ISSUE.

- **IDLE**
  - instr_ready=1.
  - Accept when instr_valid && instr_ready, and latch instr.
  - If instr[25]=1 (immediate operand), load outputs and go to ISSUE:
    - b_bus={24'b0, instr[7:0]}
    - shift_type=11
    - shift_amount_imm={instr[11:8],1'b0}
    - reg_shift=0, rrx=0
  - If instr[25]=0 (register operand):
    - In the accept cycle, rf_rd_en=1 and rf_addr=instr[3:0] (Rm), combinational from the input.
    - Go to READ_RM.
- **READ_RM**
  - Capture rf_rdata into b_bus. shift_type=instr[6:5].
  - If instr[4]=1 (register shift): rf_rd_en=1, rf_addr=instr[11:8] (Rs); go to READ_RS.
  - If instr[4]=0 (immediate shift), resolve amt=instr[11:7]:
    - amt!=0: shift_amount_imm=amt, reg_shift=0.
    - LSR #0: reg_shift=1, shift_amount_reg=32.
    - ASR #0: reg_shift=1, shift_amount_reg=32.
    - ROR #0: rrx=1, shift_type=11, shift_amount_imm=1, reg_shift=0.
    - LSL #0: pass-through, shift_amount_imm=0.
    - Go to ISSUE.
- **READ_RS**
  - Capture shift_amount_reg=rf_rdata[7:0]; reg_shift=1; shift_amount_imm=0.
  - Go to ISSUE.
- **ISSUE**
  - op_valid=1; all request outputs held constant.
  - On op_ready go to IDLE.
  - No new instruction is accepted in the ISSUE cycle.

General rules:
- rf_rd_en=0 in all states and conditions not listed above. rf_addr=0 when rf_rd_en=0.
- Unused request fields are driven to 0: shift_amount_reg when reg_shift=0, and rrx except for the ROR #0 case.

## Timing
- Reset (reset_n low, asynchronous): state=IDLE, and every output is 0 while reset is asserted: instr_ready, op_valid, b_bus, shift_type, shift_amount_imm, shift_amount_reg, reg_shift, rrx, rf_rd_en, rf_addr.
- Reset mid-operation (any state) aborts the instruction immediately. No op_valid is produced for it.
- instr_ready rises in the first cycle with reset_n high.
- Latency from the accept edge T to op_valid high:
  - immediate operand: T+1
  - register operand, immediate shift: T+2
  - register operand, register shift: T+3
- Register-file reads:
  - The Rm read is issued in the accept cycle.
  - rf_rdata for Rm is sampled at the end of READ_RM.
  - rf_rdata for Rs is sampled at the end of READ_RS.
- op_valid stays high, with all fields stable, until the cycle in which op_ready=1. It drops on the following edge.
- op_ready while op_valid=0 is ignored.
- instr_valid while instr_ready=0 is ignored. Nothing is queued.
- Maximum throughput is one instruction per 2 cycles (immediate operand, op_ready tied high).
- Rs=Rm is legal: two separate reads are performed.

## Test plan
- **Immediate operand.** instr=0x02A0_03FF (I=1, rot=3, imm=0xFF), op_ready=1 → at T+1: op_valid=1, b_bus=0x000000FF, shift_type=11, shift_amount_imm=6, reg_shift=0. instr_ready=1 at T+2.
- **Register operand, immediate shift.** Rm=r2=0x80000001; instr field LSL #4 → at T+2: b_bus=0x80000001, shift_type=00, shift_amount_imm=4, reg_shift=0.
- **Special encodings, Rm=0xF0000000.**
  - LSR #0 → reg_shift=1, shift_amount_reg=32, shift_type=01.
  - ASR #0 → same with shift_type=10.
  - ROR #0 → rrx=1, shift_type=11, shift_amount_imm=1.
- **Register shift.** Rm=r1=0x12345678, Rs=r3=0x00000108, ROR by register → rf_addr sequence 1 then 3. At T+3: shift_amount_reg=0x08, reg_shift=1, shift_type=11.
- **Backpressure.** Hold op_ready=0 for 5 cycles → op_valid and all fields stable. instr_valid pulses in that window are not accepted. op_ready=1 → return to IDLE next cycle.
- **Reset.** Assert reset_n=0 asynchronously (mid-clock) while in READ_RS → all outputs 0 immediately. After release: IDLE, instr_ready=1, and no op_valid for the aborted instruction.
